// File: rtl/uart_to_bus.sv
// Buffers bytes from a UART receiver and writes each one to a serial bus slave:
// the address and data are shifted out MSB first, then the slave's ready is awaited.
module uart_to_bus #(
  parameter int N          = 8,
  parameter int ADN        = 12,
  parameter int BASE_ADDR  = 0,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] rx_data,
  input  logic         rx_valid,
  input  logic         bus_grant,
  input  logic         slave_ready,
  output logic         bus_req,
  output logic         valid,
  output logic         wren,
  output logic         addr_bit,
  output logic         data_bit,
  output logic         burst_en,
  output logic         fifo_full,
  output logic         overflow,
  output logic         timeout_err,
  output logic [2:0]   state_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = $clog2(ADN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    SHIFT    = 3'd2,
    WAIT_RDY = 3'd3
  } state_t;

  // ---------------- receive buffer ----------------
  logic [N-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic          fifo_empty, fifo_full_int;
  logic          pop, push, drop;
  logic          overflow_reg;
  logic [N-1:0]  fifo_head;

  assign fifo_empty    = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full_int = (wr_ptr_reg[PW-1] != rd_ptr_reg[PW-1]) &&
                         (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // A full buffer still takes a byte when the head leaves in the same cycle.
  assign push      = rx_valid && (!fifo_full_int || pop);
  assign drop      = rx_valid && fifo_full_int && !pop;
  assign fifo_head = fifo_mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push)
      fifo_mem[wr_ptr_reg[AW-1:0]] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // ---------------- transfer engine ----------------
  state_t          state_reg, state_next;
  logic [KW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic [TW-1:0]   wait_cnt_reg, wait_cnt_next;
  logic [ADN-1:0]  addr_sh_reg, addr_sh_next;
  logic [ADN-1:0]  data_sh_reg, data_sh_next;
  logic [ADN-1:0]  addr_cnt_reg, addr_cnt_next;
  logic            timeout_set, timeout_reg;
  logic            bus_req_reg, bus_req_next;
  logic            valid_reg, valid_next;
  logic            addr_bit_reg, addr_bit_next;
  logic            data_bit_reg, data_bit_next;

  // Bus outputs are computed for the state being entered and registered, so the
  // first address bit shows up in the first SHIFT cycle.
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    addr_sh_next  = addr_sh_reg;
    data_sh_next  = data_sh_reg;
    addr_cnt_next = addr_cnt_reg;
    pop           = 1'b0;
    timeout_set   = 1'b0;
    addr_bit_next = 1'b0;
    data_bit_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop          = 1'b1;
          addr_sh_next = addr_cnt_reg;
          // Zero-extending the byte aligns it with the last N address bits.
          data_sh_next = ADN'(fifo_head);
          state_next   = REQ;
        end
      end
      REQ: begin
        if (bus_grant) begin
          state_next    = SHIFT;
          bit_cnt_next  = '0;
          addr_bit_next = addr_sh_reg[ADN-1];
          data_bit_next = data_sh_reg[ADN-1];
          addr_sh_next  = addr_sh_reg << 1;
          data_sh_next  = data_sh_reg << 1;
        end
      end
      SHIFT: begin
        if (bit_cnt_reg == KW'(ADN - 1)) begin
          state_next    = WAIT_RDY;
          wait_cnt_next = '0;
        end else begin
          bit_cnt_next  = bit_cnt_reg + KW'(1);
          addr_bit_next = addr_sh_reg[ADN-1];
          data_bit_next = data_sh_reg[ADN-1];
          addr_sh_next  = addr_sh_reg << 1;
          data_sh_next  = data_sh_reg << 1;
        end
      end
      WAIT_RDY: begin
        if (slave_ready) begin
          addr_cnt_next = addr_cnt_reg + ADN'(1);
          state_next    = IDLE;
        end else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
          timeout_set = 1'b1;
          state_next  = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + TW'(1);
        end
      end
      default: state_next = IDLE;
    endcase

    bus_req_next = (state_next != IDLE);
    valid_next   = (state_next == SHIFT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      wait_cnt_reg <= '0;
      addr_sh_reg  <= '0;
      data_sh_reg  <= '0;
      addr_cnt_reg <= ADN'(BASE_ADDR);
      timeout_reg  <= 1'b0;
      bus_req_reg  <= 1'b0;
      valid_reg    <= 1'b0;
      addr_bit_reg <= 1'b0;
      data_bit_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      addr_sh_reg  <= addr_sh_next;
      data_sh_reg  <= data_sh_next;
      addr_cnt_reg <= addr_cnt_next;
      if (timeout_set)
        timeout_reg <= 1'b1;
      bus_req_reg  <= bus_req_next;
      valid_reg    <= valid_next;
      addr_bit_reg <= addr_bit_next;
      data_bit_reg <= data_bit_next;
    end
  end

  assign bus_req     = bus_req_reg;
  assign valid       = valid_reg;
  assign wren        = valid_reg;
  assign addr_bit    = addr_bit_reg;
  assign data_bit    = data_bit_reg;
  assign burst_en    = 1'b0;
  assign fifo_full   = fifo_full_int;
  assign overflow    = overflow_reg;
  assign timeout_err = timeout_reg;
  assign state_out   = state_reg;

endmodule

// File: tb/tb_uart_to_bus.sv
// Bench for uart_to_bus: two instances (base address 0 and 0xFFF) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_uart_to_bus;

  localparam int N     = 8;
  localparam int ADN   = 12;
  localparam int DEPTH = 4;
  localparam int TMO   = 255;
  localparam logic [ADN-1:0] BASE1 = 12'hFFF;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] rx_data;
  logic         rx_valid, bus_grant, slave_ready;
  logic [1:0]   bus_req, valid, wren, addr_bit, data_bit, burst_en, fifo_full, overflow, timeout_err;
  logic [2:0]   state_out [2];

  always #5 clk = ~clk;

  uart_to_bus u_dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_grant(bus_grant), .slave_ready(slave_ready),
    .bus_req(bus_req[0]), .valid(valid[0]), .wren(wren[0]), .addr_bit(addr_bit[0]),
    .data_bit(data_bit[0]), .burst_en(burst_en[0]), .fifo_full(fifo_full[0]),
    .overflow(overflow[0]), .timeout_err(timeout_err[0]), .state_out(state_out[0])
  );

  uart_to_bus #(.BASE_ADDR(12'hFFF)) u_dut_wrap (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .bus_grant(bus_grant), .slave_ready(slave_ready),
    .bus_req(bus_req[1]), .valid(valid[1]), .wren(wren[1]), .addr_bit(addr_bit[1]),
    .data_bit(data_bit[1]), .burst_en(burst_en[1]), .fifo_full(fifo_full[1]),
    .overflow(overflow[1]), .timeout_err(timeout_err[1]), .state_out(state_out[1])
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Reference model: buffer contents, transfer phase and address counters.
  logic [N-1:0]   mq[$];
  int             m_stage, m_k, m_w;
  logic [N-1:0]   m_byte;
  logic [ADN-1:0] m_addr_cnt [2];
  logic [ADN-1:0] m_cur_addr [2];
  logic           m_ovf, m_tmo;

  // Captured bus writes.
  logic [ADN-1:0] cap_a [2];
  logic [ADN-1:0] cap_d [2];
  int             cap_len [2];
  int             cap_start [2];
  logic [ADN-1:0] b_addr0[$], b_data0[$], b_addr1[$];
  int             b_start0[$];
  int             req_wait_cnt;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    m_stage = 0; m_k = 0; m_w = 0; m_byte = '0;
    m_addr_cnt[0] = '0; m_addr_cnt[1] = BASE1;
    m_cur_addr[0] = '0; m_cur_addr[1] = '0;
    m_ovf = 1'b0; m_tmo = 1'b0;
  endtask

  task automatic model_step();
    bit pop;
    pop = (m_stage == 0) && (mq.size() > 0);
    if (pop) m_byte = mq.pop_front();
    if (rx_valid) begin
      if (mq.size() < DEPTH) mq.push_back(rx_data);
      else m_ovf = 1'b1;
    end
    case (m_stage)
      0: if (pop) begin
           m_cur_addr[0] = m_addr_cnt[0];
           m_cur_addr[1] = m_addr_cnt[1];
           m_stage = 1;
         end
      1: if (bus_grant) begin m_stage = 2; m_k = 0; end
      2: if (m_k == ADN - 1) begin m_stage = 3; m_w = 0; end
         else m_k++;
      3: if (slave_ready) begin
           m_addr_cnt[0] = m_addr_cnt[0] + 1'b1;
           m_addr_cnt[1] = m_addr_cnt[1] + 1'b1;
           m_stage = 0;
         end else if (m_w == TMO - 1) begin
           m_tmo = 1'b1; m_stage = 0;
         end else m_w++;
      default: m_stage = 0;
    endcase
  endtask

  task automatic check_outputs();
    logic eb, ev, ea, ed;
    for (int i = 0; i < 2; i++) begin
      ev = (m_stage == 2);
      eb = (m_stage != 0);
      ea = ev ? m_cur_addr[i][ADN-1-m_k] : 1'b0;
      ed = (ev && m_k >= ADN - N) ? m_byte[ADN-1-m_k] : 1'b0;
      chk($sformatf("bus_req%0d@%0d", i, cyc), bus_req[i], eb);
      chk($sformatf("valid%0d@%0d", i, cyc), valid[i], ev);
      chk($sformatf("wren%0d@%0d", i, cyc), wren[i], ev);
      chk($sformatf("addr_bit%0d@%0d", i, cyc), addr_bit[i], ea);
      chk($sformatf("data_bit%0d@%0d", i, cyc), data_bit[i], ed);
      chk($sformatf("burst_en%0d@%0d", i, cyc), burst_en[i], 0);
      chk($sformatf("fifo_full%0d@%0d", i, cyc), fifo_full[i], mq.size() == DEPTH);
      chk($sformatf("overflow%0d@%0d", i, cyc), overflow[i], m_ovf);
      chk($sformatf("timeout_err%0d@%0d", i, cyc), timeout_err[i], m_tmo);
      chk($sformatf("state%0d@%0d", i, cyc), state_out[i], m_stage);

      if (valid[i]) begin
        if (cap_len[i] == 0) cap_start[i] = cyc;
        cap_a[i] = {cap_a[i][ADN-2:0], addr_bit[i]};
        cap_d[i] = {cap_d[i][ADN-2:0], data_bit[i]};
        cap_len[i]++;
      end else if (cap_len[i] > 0) begin
        chk($sformatf("burst_len%0d@%0d", i, cyc), cap_len[i], ADN);
        $display("write dut%0d cycle %0d addr=%03h data=%03h", i, cap_start[i], cap_a[i], cap_d[i]);
        if (i == 0) begin
          b_addr0.push_back(cap_a[0]); b_data0.push_back(cap_d[0]); b_start0.push_back(cap_start[0]);
        end else begin
          b_addr1.push_back(cap_a[1]);
        end
        cap_len[i] = 0;
      end
    end
    if (bus_req[0] && !valid[0] && state_out[0] == 3'd1) req_wait_cnt++;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_outputs();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rx_valid = 1'b0; bus_grant = 1'b0; slave_ready = 1'b0; rx_data = '0;
    #1;
    cap_len[0] = 0; cap_len[1] = 0;
    b_addr0.delete(); b_data0.delete(); b_addr1.delete(); b_start0.delete();
    req_wait_cnt = 0;
    model_reset();
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
  endtask

  logic [N-1:0] t2_bytes [6];

  initial begin
    reset = 1'b1;
    rx_valid = 1'b0; bus_grant = 1'b0; slave_ready = 1'b0; rx_data = '0;
    model_reset();
    @(negedge clk);

    // Single byte, immediate grant and ready; also the wrap instance.
    apply_reset();
    bus_grant = 1'b1; slave_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'hA5; tick();
    rx_valid = 1'b0; repeat (ADN + 6) tick();
    chk("t1_writes", b_addr0.size(), 1);
    if (b_addr0.size() >= 1) begin
      chk("t1_addr", b_addr0[0], 0);
      chk("t1_data_bits", b_data0[0], 12'b0000_1010_0101);
      chk("t1_wrap_base", b_addr1[0], 12'hFFF);
      chk("t1_first_shift_cycle", b_start0[0], 3);
    end
    rx_valid = 1'b1; rx_data = 8'h3C; tick();
    rx_valid = 1'b0; repeat (ADN + 6) tick();
    chk("t1_second_writes", b_addr0.size(), 2);
    if (b_addr0.size() >= 2) begin
      chk("t1_next_addr", b_addr0[1], 1);
      chk("t1_wrap_addr", b_addr1[1], 0);
      chk("t1_second_data", b_data0[1], 8'h3C);
    end

    // Burst of bytes while the bus is withheld: fill, then overflow.
    apply_reset();
    for (int i = 0; i < 6; i++) t2_bytes[i] = N'($urandom);
    for (int i = 0; i < 6; i++) begin
      rx_valid = 1'b1; rx_data = t2_bytes[i]; tick();
      if (i == 4) begin
        chk("t2_full", fifo_full[0], 1);
        chk("t2_no_overflow_yet", overflow[0], 0);
      end
    end
    chk("t2_overflow", overflow[0], 1);
    rx_valid = 1'b0; bus_grant = 1'b1; slave_ready = 1'b1;
    repeat (6 * (ADN + 3) + 10) tick();
    chk("t2_writes", b_addr0.size(), 5);
    for (int i = 0; i < 5 && i < b_addr0.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), b_addr0[i], i);
      chk($sformatf("t2_data%0d", i), b_data0[i], t2_bytes[i]);
    end
    if (b_start0.size() >= 3)
      chk("t2_spacing", b_start0[2] - b_start0[1], ADN + 3);

    // Grant held off for ten request cycles.
    apply_reset();
    slave_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h5A; tick();
    rx_valid = 1'b0; repeat (10) tick();
    bus_grant = 1'b1; tick();
    repeat (ADN + 4) tick();
    chk("t3_req_cycles", req_wait_cnt, 10);
    chk("t3_writes", b_addr0.size(), 1);

    // No ready: timeout after 255 wait cycles, address reused.
    apply_reset();
    bus_grant = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h77; tick();
    rx_valid = 1'b0; repeat (268) tick();
    chk("t4_before_timeout", timeout_err[0], 0);
    tick();
    chk("t4_timeout", timeout_err[0], 1);
    slave_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h11; tick();
    rx_valid = 1'b0; repeat (ADN + 6) tick();
    chk("t4_writes", b_addr0.size(), 2);
    if (b_addr0.size() >= 2) begin
      chk("t4_reused_addr", b_addr0[1], 0);
      chk("t4_reused_addr_wrap", b_addr1[1], 12'hFFF);
    end

    // Reset in the middle of the shift.
    apply_reset();
    bus_grant = 1'b1; slave_ready = 1'b1;
    rx_valid = 1'b1; rx_data = 8'h96; tick();
    rx_data = 8'h69; tick();
    rx_valid = 1'b0; repeat (6) tick();
    chk("t5_shifting", valid[0], 1);
    reset = 1'b1;
    #1;
    chk("t5_valid_async", valid[0], 0);
    apply_reset();
    bus_grant = 1'b1; slave_ready = 1'b1;
    repeat (20) tick();
    chk("t5_fifo_emptied", b_addr0.size(), 0);
    rx_valid = 1'b1; rx_data = 8'hC3; tick();
    rx_valid = 1'b0; repeat (ADN + 6) tick();
    chk("t5_writes", b_addr0.size(), 1);
    if (b_addr0.size() >= 1) begin
      chk("t5_base_addr", b_addr0[0], 0);
      chk("t5_base_addr_wrap", b_addr1[0], 12'hFFF);
      chk("t5_data", b_data0[0], 8'hC3);
    end

    // Random traffic, with periodic stretches where ready never comes.
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      rx_valid    = ($urandom_range(0, 99) < 30);
      rx_data     = N'($urandom);
      bus_grant   = ($urandom_range(0, 99) < 70);
      slave_ready = ((n / 600) % 3 == 2) ? 1'b0 : ($urandom_range(0, 99) < 45);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
